cam_loader: RTL
===============

Name: cam_loader

Overview:
- Host-side load/readback sequencer sitting directly upstream of the CAM array.
- Accepts a burst command (op, base row, count), then either:
  - streams write words from a valid/ready input into consecutive CAM rows, or
  - reads consecutive rows back out to a valid/ready output.
- Generates the CAM's row address, write data, write-enable and internal-column select with the timing the array requires.
- The array's row write-enable register captures one row per cycle and is cleared only by a cycle with wea low, so every write needs a two-cycle set/hold sequence.

Parameters:
- WORD_SIZE, 8, CAM word width in bits.
- CELL_QUANT, 512, number of CAM rows.
- ADDR_W, clogb2(CELL_QUANT), row address width (derived; do not override).
- RD_LAT, 1, cycles from cam_addr change to valid cam_dout.

Ports:
- CLK100MHZ  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0=write burst, 1=read burst, 2=clear (optional feature), 3=illegal
- cmd_base  in  ADDR_W  first row
- cmd_count  in  ADDR_W+1  number of rows, 1..CELL_QUANT
- cmd_col  in  1  internal column select for the burst
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted
- wr_data  in  WORD_SIZE  write word
- rd_valid  out  1  readback word valid
- rd_ready  in  1  readback sink ready
- rd_data  out  WORD_SIZE  readback word
- cam_addr  out  ADDR_W  to CAM addr_in
- cam_col  out  1  to CAM internal_col_in
- cam_din  out  WORD_SIZE  to CAM dina
- cam_wea  out  1  to CAM wea
- cam_dout  in  WORD_SIZE  from CAM doutb
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst finishes
- err  out  1  one-cycle pulse on command rejection

Behaviour:
- Reset values:
  - all outputs 0, except cmd_ready=1;
  - state IDLE; row counter and remaining count 0.
  - Reset mid-burst aborts at once, with no done pulse. cam_wea=0 on the cycle after reset is seen, so the array's per-row enables get cleared.
- FSM states: IDLE, WR_WAIT, WR_SET, WR_HOLD, RD_ADDR, RD_WAIT, RD_OUT, FINISH.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch base, count and col.
  - Reject with err pulse and stay in IDLE if:
    - count==0;
    - base+count > CELL_QUANT (computed at ADDR_W+2 bits, so it cannot wrap);
    - op is illegal.
  - Otherwise op0 -> WR_WAIT, op1 -> RD_ADDR.
- Write path:
  - WR_WAIT: wr_ready=1. On wr_valid, register the word into cam_din and go to WR_SET.
  - WR_SET: cam_wea=1, cam_addr=row.
  - WR_HOLD: cam_wea=0; cam_din and cam_addr stay stable. Decrement remaining and increment row. If remaining hits 0 go to FINISH, else WR_WAIT.
  - Peak throughput: 1 word per 3 cycles. cam_wea is never high on two consecutive cycles.
- Read path:
  - RD_ADDR: drive cam_addr=row.
  - RD_WAIT: wait RD_LAT cycles, then capture cam_dout into rd_data.
  - RD_OUT: rd_valid=1, with rd_data held stable until rd_ready. On the handshake, advance row; go to FINISH if remaining is 0, else RD_ADDR.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. The next command can be accepted on the following cycle.
- busy=1 in every state except IDLE and FINISH. cmd_ready=0 while busy.
- cam_col holds the latched cmd_col for the whole burst; it is 0 in IDLE.
- Row counter never wraps; the range check guarantees the last row is at most CELL_QUANT-1.
- wr_valid outside WR_WAIT is ignored (not consumed). rd_ready is ignored when rd_valid=0.

Optional Feature:
- Macro: CAM_LOADER_CLEAR_EN.
- Defined: op2 is legal. It writes zero to rows base..base+count-1 using WR_SET/WR_HOLD pairs, with no wr_* handshake (WR_WAIT is skipped). It ends with a done pulse.
- Undefined: op2 is illegal and is rejected with an err pulse.

Decomposition:
- Shared package cam_pkg:
  - op encodings (OP_WRITE, OP_READ, OP_CLEAR);
  - the FSM state enum;
  - the clogb2 function, shared with the CAM array.
- No sub-module needed. Keep the FSM, counters and the read capture register in one module.

Test Plan:
- Write burst base=5, count=3, data A1,B2,C3 with wr_valid held high:
  - cam_wea pulses at addr 5,6,7, each followed by a wea=0 hold cycle with din stable;
  - one done pulse; array rows 5..7 = A1,B2,C3.
- Read burst base=5, count=3, rd_ready toggling 1/0:
  - rd_data sequence A1,B2,C3, each held stable while rd_valid=1 and rd_ready=0;
  - done after the third handshake.
- Command base=510, count=3 with CELL_QUANT=512 -> err pulse, busy stays 0, no cam_wea.
- Command with count=0 -> err pulse, no burst.
- Assert rst mid write burst, after the second word -> all outputs reset next cycle, cmd_ready=1, no done; a fresh write of row 0 then succeeds.
- Op2 with base=0, count=4:
  - CAM_LOADER_CLEAR_EN defined: rows 0..3 read back 00.
  - Undefined: err pulse.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the CAM loader and the CAM array.
// Holds the burst op encodings, the loader FSM state type and clogb2.
package cam_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_SET, WR_HOLD, RD_ADDR, RD_WAIT, RD_OUT, FINISH
  } state_t;

  // Bits needed to address n entries (ceil(log2(n))).
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cam_loader.sv
// cam_loader: host-side burst load/readback sequencer for the CAM array.
// Write bursts drive each row as a WR_SET (wea=1) / WR_HOLD (wea=0) pair so
// the array's row-enable register is cleared between rows. Read bursts wait
// RD_LAT cycles after cam_addr moves before capturing cam_dout.
// Optional: define CAM_LOADER_CLEAR_EN to make op2 (clear rows to zero) legal.
module cam_loader
  import cam_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  parameter int ADDR_W     = clogb2(CELL_QUANT),
  parameter int RD_LAT     = 1
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_base,
  input  logic [ADDR_W:0]      cmd_count,
  input  logic                 cmd_col,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WORD_SIZE-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic [ADDR_W-1:0]    cam_addr,
  output logic                 cam_col,
  output logic [WORD_SIZE-1:0] cam_din,
  output logic                 cam_wea,
  input  logic [WORD_SIZE-1:0] cam_dout,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t          state;
  logic [ADDR_W:0] row;      // one spare bit so row+1 past the last row never wraps
  logic [ADDR_W:0] rem;
  logic [ADDR_W:0] row_inc;
  logic [7:0]      lat_cnt;
  logic            clr;      // current burst is a clear (no wr_* handshake)
  logic [ADDR_W+1:0] end_row;
  logic            op_ok;
  logic            cmd_bad;

  assign row_inc = row + (ADDR_W+1)'(1);
  assign end_row = {2'b00, cmd_base} + {1'b0, cmd_count};

  // Command legality: nonzero count, burst fits in the array, known op.
  always_comb begin
`ifdef CAM_LOADER_CLEAR_EN
    op_ok = (cmd_op == OP_WRITE) || (cmd_op == OP_READ) || (cmd_op == OP_CLEAR);
`else
    op_ok = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
`endif
    cmd_bad = (cmd_count == '0) || (end_row > (ADDR_W+2)'(CELL_QUANT)) || !op_ok;
  end

  // Burst sequencer; every output is registered and set on entry to its state.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      rem       <= '0;
      lat_cnt   <= '0;
      clr       <= 1'b0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      cam_addr  <= '0;
      cam_col   <= 1'b0;
      cam_din   <= '0;
      cam_wea   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_bad) begin
            err <= 1'b1;
          end else begin
            row       <= {1'b0, cmd_base};
            rem       <= cmd_count;
            cam_col   <= cmd_col;
            cam_addr  <= cmd_base;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            clr       <= 1'b0;
            case (cmd_op)
              OP_READ: state <= RD_ADDR;
`ifdef CAM_LOADER_CLEAR_EN
              OP_CLEAR: begin
                clr     <= 1'b1;
                cam_din <= '0;
                cam_wea <= 1'b1;
                state   <= WR_SET;
              end
`endif
              default: begin
                wr_ready <= 1'b1;
                state    <= WR_WAIT;
              end
            endcase
          end
        end
        WR_WAIT: if (wr_valid) begin
          cam_din  <= wr_data;
          cam_addr <= row[ADDR_W-1:0];
          cam_wea  <= 1'b1;
          wr_ready <= 1'b0;
          state    <= WR_SET;
        end
        WR_SET: begin
          cam_wea <= 1'b0;
          state   <= WR_HOLD;
        end
        WR_HOLD: begin
          rem <= rem - (ADDR_W+1)'(1);
          row <= row_inc;
          if (rem == (ADDR_W+1)'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else if (clr) begin
            cam_addr <= row_inc[ADDR_W-1:0];
            cam_wea  <= 1'b1;
            state    <= WR_SET;
          end else begin
            wr_ready <= 1'b1;
            state    <= WR_WAIT;
          end
        end
        RD_ADDR: begin
          lat_cnt <= 8'(RD_LAT - 1);
          state   <= RD_WAIT;
        end
        RD_WAIT: if (lat_cnt == '0) begin
          rd_data  <= cam_dout;
          rd_valid <= 1'b1;
          state    <= RD_OUT;
        end else begin
          lat_cnt <= lat_cnt - 8'd1;
        end
        RD_OUT: if (rd_ready) begin
          rd_valid <= 1'b0;
          rem      <= rem - (ADDR_W+1)'(1);
          row      <= row_inc;
          if (rem == (ADDR_W+1)'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            cam_addr <= row_inc[ADDR_W-1:0];
            state    <= RD_ADDR;
          end
        end
        FINISH: begin
          cmd_ready <= 1'b1;
          cam_col   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
